// File: rtl/control_ascensor_if.sv
// Bus between the request memory (master) and the car controller (slave).
// The obstaculo sensor line exists only when OBSTACULO_EN is defined.
interface control_ascensor_if;
   logic [3:0] memoria;
   logic [1:0] piso_m;
   logic [1:0] accion_m;
   logic       puertas_m;
   logic       llegada;
`ifdef OBSTACULO_EN
   logic       obstaculo;

   modport master (
      output memoria, obstaculo,
      input  piso_m, accion_m, puertas_m, llegada
   );
   modport slave (
      input  memoria, obstaculo,
      output piso_m, accion_m, puertas_m, llegada
   );
`else
   modport master (
      output memoria,
      input  piso_m, accion_m, puertas_m, llegada
   );
   modport slave (
      input  memoria,
      output piso_m, accion_m, puertas_m, llegada
   );
`endif
endinterface

// File: rtl/control_ascensor.sv
// Elevator car motion/door controller; floor position is tracked by timing travel.
// Define OBSTACULO_EN to add the door obstruction sensor that holds the doors open.
module control_ascensor #(
   parameter int unsigned T_PISO   = 50_000_000,
   parameter int unsigned T_PUERTA = 100_000_000,
   parameter int unsigned CNT_W    = 28
) (
   input  logic         clk,
   input  logic         rst,
   control_ascensor_if.slave bus
);

   typedef enum logic [2:0] {StReposo, StSubiendo, StBajando, StLlegada, StAbierta} estado_e;

   localparam logic [CNT_W-1:0] FinPiso   = CNT_W'(T_PISO - 1);
   localparam logic [CNT_W-1:0] FinPuerta = CNT_W'(T_PUERTA - 1);
   localparam logic [1:0]       AccParado = 2'd0;
   localparam logic [1:0]       AccSube   = 2'd1;
   localparam logic [1:0]       AccBaja   = 2'd2;

   estado_e          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       piso_q, piso_d;
   logic [1:0]       accion_q, accion_d;
   logic             puertas_q, puertas_d;
   logic             llegada_q, llegada_d;
   logic             obj_vld_q;
   logic [1:0]       obj_q;
   logic             dec_vld;
   logic [1:0]       dec_piso;
   logic             obst;
   logic             sube;

`ifdef OBSTACULO_EN
   assign obst = bus.obstaculo;
`else
   assign obst = 1'b0;
`endif

   always_comb begin
      dec_vld  = 1'b1;
      dec_piso = 2'd0;
      case (bus.memoria)
         4'd1, 4'd5:        dec_piso = 2'd0;
         4'd2, 4'd6, 4'd7:  dec_piso = 2'd1;
         4'd3, 4'd8, 4'd9:  dec_piso = 2'd2;
         4'd4, 4'd10:       dec_piso = 2'd3;
         default:           dec_vld  = 1'b0;
      endcase
   end

   assign sube = (accion_q == AccSube);

   always_comb begin
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      piso_d    = piso_q;
      accion_d  = accion_q;
      puertas_d = puertas_q;
      llegada_d = 1'b0;
      unique case (estado_q)
         StReposo: begin
            accion_d  = AccParado;
            puertas_d = 1'b0;
            cnt_d     = '0;
            if (obj_vld_q) begin
               if (obj_q == piso_q) begin
                  estado_d  = StAbierta;
                  puertas_d = 1'b1;
               end else if (obj_q > piso_q) begin
                  estado_d = StSubiendo;
                  accion_d = AccSube;
               end else begin
                  estado_d = StBajando;
                  accion_d = AccBaja;
               end
            end
         end
         StSubiendo, StBajando: begin
            if (cnt_q == FinPiso) begin
               cnt_d     = '0;
               llegada_d = 1'b1;
               estado_d  = StLlegada;
               // Guards keep the 2-bit floor from wrapping at the shaft ends.
               if (estado_q == StSubiendo && piso_q != 2'd3) piso_d = piso_q + 2'd1;
               if (estado_q == StBajando && piso_q != 2'd0)  piso_d = piso_q - 2'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StLlegada: begin
            cnt_d = '0;
            if (obj_vld_q && obj_q == piso_q) begin
               estado_d  = StAbierta;
               accion_d  = AccParado;
               puertas_d = 1'b1;
            end else if (obj_vld_q && sube && obj_q > piso_q) begin
               estado_d = StSubiendo;
            end else if (obj_vld_q && !sube && obj_q < piso_q) begin
               estado_d = StBajando;
            end else begin
               // Reversal or no request: stop here and decide again from rest.
               estado_d = StReposo;
               accion_d = AccParado;
            end
         end
         StAbierta: begin
            if (obst) begin
               cnt_d = '0;
            end else if (cnt_q == FinPuerta) begin
               cnt_d     = '0;
               estado_d  = StReposo;
               puertas_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            estado_d  = StReposo;
            cnt_d     = '0;
            accion_d  = AccParado;
            puertas_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_q  <= StReposo;
         cnt_q     <= '0;
         piso_q    <= 2'd0;
         accion_q  <= AccParado;
         puertas_q <= 1'b0;
         llegada_q <= 1'b0;
         obj_vld_q <= 1'b0;
         obj_q     <= 2'd0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         piso_q    <= piso_d;
         accion_q  <= accion_d;
         puertas_q <= puertas_d;
         llegada_q <= llegada_d;
         // Registered target sample; decisions act on it one edge later.
         obj_vld_q <= dec_vld;
         obj_q     <= dec_piso;
      end
   end

   assign bus.piso_m    = piso_q;
   assign bus.accion_m  = accion_q;
   assign bus.puertas_m = puertas_q;
   assign bus.llegada   = llegada_q;

endmodule

// File: tb/tb_control_ascensor.sv
// Self-checking bench for control_ascensor: directed vector table, obstruction
// sequence (OBSTACULO_EN builds) and randomized run against a reference model.
module tb_control_ascensor;

   localparam int TP = 4;
   localparam int TD = 3;

   localparam int MIdle  = 0;
   localparam int MMove  = 1;
   localparam int MArriv = 2;
   localparam int MDoor  = 3;

   typedef struct {
      logic       r;
      logic [3:0] mem;
      int         n;
      int         piso;
      int         acc;
      int         pu;
      int         ll;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Reference model: floor, direction, remaining cycles, pending target.
   int m_piso = 0;
   int m_dir = 0;
   int m_mode = MIdle;
   int m_remain = 0;
   int m_pend = -1;
   bit m_arrive = 1'b0;

   vec_t tbl[$];

   control_ascensor_if bus ();

   control_ascensor #(
      .T_PISO  (TP),
      .T_PUERTA(TD),
      .CNT_W   (28)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [3:0] mem, input int n, input int piso,
                               input int acc, input int pu, input int ll);
      vec_t v;
      v.r = r; v.mem = mem; v.n = n; v.piso = piso; v.acc = acc; v.pu = pu; v.ll = ll;
      return v;
   endfunction

   function automatic int decode(input logic [3:0] m);
      case (m)
         4'd1, 4'd5:       return 0;
         4'd2, 4'd6, 4'd7: return 1;
         4'd3, 4'd8, 4'd9: return 2;
         4'd4, 4'd10:      return 3;
         default:          return -1;
      endcase
   endfunction

   function automatic int m_accion();
      if (m_mode == MMove || m_mode == MArriv) return (m_dir > 0) ? 1 : 2;
      return 0;
   endfunction

   task automatic model_step(input logic r, input logic [3:0] m, input bit o);
      int tgt;
      m_arrive = 1'b0;
      if (!r) begin
         m_piso = 0; m_dir = 0; m_mode = MIdle; m_remain = 0; m_pend = -1;
         return;
      end
      tgt    = m_pend;
      m_pend = decode(m);
      case (m_mode)
         MIdle: begin
            if (tgt >= 0) begin
               if (tgt == m_piso) begin
                  m_mode = MDoor; m_remain = TD;
               end else begin
                  m_mode = MMove; m_remain = TP; m_dir = (tgt > m_piso) ? 1 : -1;
               end
            end
         end
         MMove: begin
            m_remain--;
            if (m_remain == 0) begin
               m_piso += m_dir; m_arrive = 1'b1; m_mode = MArriv;
            end
         end
         MArriv: begin
            if (tgt == m_piso) begin
               m_mode = MDoor; m_remain = TD;
            end else if (tgt >= 0 && (tgt - m_piso) * m_dir > 0) begin
               m_mode = MMove; m_remain = TP;
            end else begin
               m_mode = MIdle;
            end
         end
         default: begin
            if (o) m_remain = TD;
            else m_remain--;
            if (m_remain == 0) m_mode = MIdle;
         end
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge: apply inputs, clock once, advance model, return at negedge.
   task automatic step(input logic r, input logic [3:0] m, input bit o);
      rst         = r;
      bus.memoria = m;
`ifdef OBSTACULO_EN
      bus.obstaculo = o;
`endif
      @(posedge clk);
      model_step(r, m, o);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      check({tag, " piso"},    int'(bus.piso_m),    m_piso);
      check({tag, " accion"},  int'(bus.accion_m),  m_accion());
      check({tag, " puertas"}, int'(bus.puertas_m), int'(m_mode == MDoor));
      check({tag, " llegada"}, int'(bus.llegada),   int'(m_arrive));
   endtask

   initial begin
      int         ncyc;
      logic [3:0] mem;
      logic       r;
      bit         o;

      bus.memoria = 4'd9;
`ifdef OBSTACULO_EN
      bus.obstaculo = 1'b0;
`endif
      // rst, memoria, cycles, then expected piso, accion, puertas, llegada
      tbl.push_back(mk(1'b0, 4'd9, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd9, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd9, 4, 0, 1, 0, 0));
      tbl.push_back(mk(1'b1, 4'd9, 1, 1, 1, 0, 1));
      tbl.push_back(mk(1'b1, 4'd9, 4, 1, 1, 0, 0));
      tbl.push_back(mk(1'b1, 4'd9, 1, 2, 1, 0, 1));
      tbl.push_back(mk(1'b1, 4'd0, 3, 2, 0, 1, 0));
      tbl.push_back(mk(1'b1, 4'd0, 2, 2, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd8, 1, 2, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd0, 3, 2, 0, 1, 0));
      tbl.push_back(mk(1'b1, 4'd0, 1, 2, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd4, 1, 2, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd4, 1, 2, 1, 0, 0));
      tbl.push_back(mk(1'b1, 4'd1, 3, 2, 1, 0, 0));
      tbl.push_back(mk(1'b1, 4'd1, 1, 3, 1, 0, 1));
      tbl.push_back(mk(1'b1, 4'd1, 1, 3, 0, 0, 0));
      tbl.push_back(mk(1'b1, 4'd1, 4, 3, 2, 0, 0));
      tbl.push_back(mk(1'b1, 4'd1, 1, 2, 2, 0, 1));
      tbl.push_back(mk(1'b1, 4'd1, 4, 2, 2, 0, 0));
      tbl.push_back(mk(1'b1, 4'd1, 1, 1, 2, 0, 1));
      tbl.push_back(mk(1'b1, 4'd1, 4, 1, 2, 0, 0));
      tbl.push_back(mk(1'b1, 4'd1, 1, 0, 2, 0, 1));
      tbl.push_back(mk(1'b1, 4'd0, 3, 0, 0, 1, 0));
      tbl.push_back(mk(1'b1, 4'd0, 2, 0, 0, 0, 0));

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            step(tbl[i].r, tbl[i].mem, 1'b0);
            check($sformatf("vec%0d.%0d piso", i, k),    int'(bus.piso_m),    tbl[i].piso);
            check($sformatf("vec%0d.%0d accion", i, k),  int'(bus.accion_m),  tbl[i].acc);
            check($sformatf("vec%0d.%0d puertas", i, k), int'(bus.puertas_m), tbl[i].pu);
            check($sformatf("vec%0d.%0d llegada", i, k), int'(bus.llegada),   tbl[i].ll);
         end
      end

      // Reset while travelling: everything back to zero on the next edge.
      step(1'b1, 4'd3, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 4'd3, 1'b0);
      check("midtravel accion", int'(bus.accion_m), 1);
      step(1'b0, 4'd3, 1'b0);
      check("midreset piso", int'(bus.piso_m), 0);
      check("midreset accion", int'(bus.accion_m), 0);
      check("midreset puertas", int'(bus.puertas_m), 0);

`ifdef OBSTACULO_EN
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd0, 1'b0);
      check("obst open", int'(bus.puertas_m), 1);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 4'd0, 1'b1);
         check($sformatf("obst held%0d", k), int'(bus.puertas_m), 1);
      end
      ncyc = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 4'd0, 1'b0);
         ncyc++;
         if (bus.puertas_m == 1'b0) break;
      end
      check("obst close edges", ncyc, TD);
`endif

      mem = 4'd0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) mem = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 199) != 0);
         o = 1'b0;
`ifdef OBSTACULO_EN
         o = ($urandom_range(0, 7) == 0);
`endif
         step(r, mem, o);
         check_model($sformatf("rand%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
